// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scanner feeding a 74HC595 driver with tear-free shadow loads.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        disp_on,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  output logic [15:0] hc_data,
  output logic        hc_en,
  output logic [2:0]  digit_idx,
  output logic        frame_done
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [127:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  typedef enum logic {IDLE, SCAN} state_t;
  state_t r_state, w_state_nxt;
  logic [DW-1:0] r_div, w_div_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [31:0]   r_act_val, r_pend_val, w_act_val;
  logic [7:0]    r_act_dp, r_act_en, r_pend_dp, r_pend_en, w_act_dp, w_act_en;
  logic          r_pend_valid, w_pend_valid_nxt;
  logic          w_last, w_wrap, w_commit, w_lz;
  logic [3:0]    w_nib;
  logic [7:0]    w_seg;
`ifdef LEADING_ZERO_BLANK_EN
  logic          w_z;
`endif
  always_comb begin
    w_last = r_div == DW'(SCAN_DIV - 1);
    w_wrap = r_state == SCAN && disp_on && w_last && r_idx == 3'(NUM_DIGITS - 1);
    w_commit = w_wrap || (r_state == IDLE && disp_on);
    w_state_nxt = disp_on ? SCAN : IDLE;
    w_div_nxt = (r_state == SCAN && disp_on && !w_last) ? r_div + 1'b1 : '0;
    w_idx_nxt = (r_state != SCAN || !disp_on || w_wrap) ? 3'd0 : w_last ? r_idx + 3'd1 : r_idx;
    // a load landing on the commit cycle bypasses pending so it is shown without a frame of delay
    w_act_val = !w_commit ? r_act_val : load ? value : r_pend_val;
    w_act_dp = !w_commit ? r_act_dp : load ? dp_mask : r_pend_dp;
    w_act_en = !w_commit ? r_act_en : load ? digit_en : r_pend_en;
    w_pend_valid_nxt = w_commit ? 1'b0 : load ? 1'b1 : r_pend_valid;
    w_nib = w_act_val[{w_idx_nxt, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    w_z = 1'b1;
    w_lz = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_z = w_z && (!w_act_en[i] || w_act_val[i*4 +: 4] == 4'd0);
      if (w_idx_nxt == 3'(i)) w_lz = w_z;
    end
`else
    w_lz = 1'b0;
`endif
    w_seg = !w_act_en[w_idx_nxt] ? 8'hFF :
            w_lz ? {~w_act_dp[w_idx_nxt], 7'h7F} :
            {~w_act_dp[w_idx_nxt], SEG_LUT[{w_nib, 3'b000} +: 7]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_div        <= '0;
      r_idx        <= '0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_act_en     <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_en    <= '0;
      r_pend_valid <= 1'b0;
      hc_data      <= 16'hFFFF;
      hc_en        <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      r_idx        <= w_idx_nxt;
      r_act_val    <= w_act_val;
      r_act_dp     <= w_act_dp;
      r_act_en     <= w_act_en;
      r_pend_valid <= w_pend_valid_nxt;
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_mask;
        r_pend_en  <= digit_en;
      end
      hc_data      <= w_state_nxt == SCAN ? {w_seg, ~(8'h01 << w_idx_nxt)} : 16'hFFFF;
      hc_en        <= w_state_nxt == SCAN;
      frame_done   <= w_wrap;
    end
  end
  assign digit_idx = r_idx;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: table-driven frame checks plus hand sequences for shadow loads, wrap loads and display-off.
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, disp_on, load;
  logic [31:0] value;
  logic [7:0]  dp_mask, digit_en;
  logic [15:0] hc_data;
  logic        hc_en, frame_done;
  logic [2:0]  digit_idx;
  int tests = 0;
  int fails = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .disp_on(disp_on), .load(load), .value(value),
    .dp_mask(dp_mask), .digit_en(digit_en), .hc_data(hc_data), .hc_en(hc_en),
    .digit_idx(digit_idx), .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] v;
    logic [7:0]  en;
    logic [7:0]  dp;
    logic [15:0] w [8];
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp);
    disp_on = 1'b0;
    step();
    load = 1'b1; value = v; digit_en = en; dp_mask = dp;
    step();
    load = 1'b0; disp_on = 1'b1;
    step();
  endtask

  initial begin
    vecs[0] = '{32'h76543210, 8'hFF, 8'h00,
      '{16'hC0FE, 16'hF9FD, 16'hA4FB, 16'hB0F7, 16'h99EF, 16'h92DF, 16'h82BF, 16'hF87F}};
    vecs[1] = '{32'hFEDCBA98, 8'hFF, 8'hAA,
      '{16'h80FE, 16'h10FD, 16'h88FB, 16'h03F7, 16'hC6EF, 16'h21DF, 16'h86BF, 16'h0E7F}};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[2] = '{32'h00000000, 8'h0F, 8'h01,
      '{16'h40FE, 16'hFFFD, 16'hFFFB, 16'hFFF7, 16'hFFEF, 16'hFFDF, 16'hFFBF, 16'hFF7F}};
    vecs[3] = '{32'h00000105, 8'hFF, 8'h00,
      '{16'h92FE, 16'hC0FD, 16'hF9FB, 16'hFFF7, 16'hFFEF, 16'hFFDF, 16'hFFBF, 16'hFF7F}};
`else
    vecs[2] = '{32'h00000000, 8'h0F, 8'h01,
      '{16'h40FE, 16'hC0FD, 16'hC0FB, 16'hC0F7, 16'hFFEF, 16'hFFDF, 16'hFFBF, 16'hFF7F}};
    vecs[3] = '{32'h00000105, 8'hFF, 8'h00,
      '{16'h92FE, 16'hC0FD, 16'hF9FB, 16'hC0F7, 16'hC0EF, 16'hC0DF, 16'hC0BF, 16'hC07F}};
`endif
    rst = 1'b1; disp_on = 1'b0; load = 1'b0; value = '0; dp_mask = '0; digit_en = '0;
    step(2);
    chk("reset data", 32'(hc_data), 32'hFFFF);
    chk("reset en", 32'(hc_en), 0);
    chk("reset idx", 32'(digit_idx), 0);
    chk("reset fd", 32'(frame_done), 0);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      start(vecs[v].v, vecs[v].en, vecs[v].dp);
      chk($sformatf("v%0d hc_en", v), 32'(hc_en), 1);
      for (int c = 0; c < 32; c++) begin
        chk($sformatf("v%0d c%0d data", v, c), 32'(hc_data), 32'(vecs[v].w[c/4]));
        chk($sformatf("v%0d c%0d idx", v, c), 32'(digit_idx), 32'(c/4));
        chk($sformatf("v%0d c%0d fd", v, c), 32'(frame_done), 0);
        step();
      end
      chk($sformatf("v%0d wrap fd", v), 32'(frame_done), 1);
      chk($sformatf("v%0d wrap data", v), 32'(hc_data), 32'(vecs[v].w[0]));
    end

    // mid-frame load is held back until the next frame
    start(32'h76543210, 8'hFF, 8'h00);
    step(13);
    load = 1'b1; value = 32'hFFFFFFFF;
    step();
    load = 1'b0;
    chk("shadow c14", 32'(hc_data), 32'hB0F7);
    step(2);
    chk("shadow c16", 32'(hc_data), 32'h99EF);
    step(12);
    chk("shadow c28", 32'(hc_data), 32'hF87F);
    step(4);
    chk("shadow c32", 32'(hc_data), 32'h8EFE);
    chk("shadow c32 fd", 32'(frame_done), 1);
    step(4);
    chk("shadow c36", 32'(hc_data), 32'h8EFD);

    // load on the wrap cycle appears at digit 0 immediately
    step(27);
    chk("wrapload c63 data", 32'(hc_data), 32'h8E7F);
    chk("wrapload c63 fd", 32'(frame_done), 0);
    load = 1'b1; value = 32'hFFFFFFFA;
    step();
    load = 1'b0;
    chk("wrapload c64 data", 32'(hc_data), 32'h88FE);
    chk("wrapload c64 fd", 32'(frame_done), 1);
    step(4);
    chk("wrapload c68 data", 32'(hc_data), 32'h8EFD);

    // display off mid digit 5, then restart with a fresh dwell count
    start(32'h76543210, 8'hFF, 8'h00);
    step(22);
    chk("off c22 idx", 32'(digit_idx), 5);
    disp_on = 1'b0;
    step();
    chk("off en", 32'(hc_en), 0);
    chk("off data", 32'(hc_data), 32'hFFFF);
    chk("off idx", 32'(digit_idx), 0);
    chk("off fd", 32'(frame_done), 0);
    disp_on = 1'b1;
    step();
    chk("reon data", 32'(hc_data), 32'hC0FE);
    chk("reon en", 32'(hc_en), 1);
    step(3);
    chk("reon c3 idx", 32'(digit_idx), 0);
    step();
    chk("reon c4 idx", 32'(digit_idx), 1);
    chk("reon c4 data", 32'(hc_data), 32'hF9FD);

    // reset mid-scan clears the active and pending buffers
    rst = 1'b1;
    step();
    chk("midrst data", 32'(hc_data), 32'hFFFF);
    chk("midrst en", 32'(hc_en), 0);
    rst = 1'b0;
    step();
    chk("postrst blank", 32'(hc_data), 32'hFFFE);
    chk("postrst idx", 32'(digit_idx), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
